// File: rtl/ijtag_multi_sib.sv
// ----------------------------------------------------------------------------
// ijtag_multi_sib
//
// Multi-bit Segment Insertion Bit block for an IJTAG scan network. Each of the
// NUM_CH SIB bits owns one child segment. When a bit's update latch is set,
// that child is spliced into the scan path directly in front of the bit.
//
// Parameters
//   NUM_CH         : number of SIB bits / child segments (1..8)
//   RETIME_SO      : 1 = scan-out through a latch that is transparent while tck
//                    is low; 0 = scan-out taken directly from the last SIB bit
//   CAPTURE_STATUS : 0 = capture loads zeros; 1 = capture loads the update latch
//
// Ports
//   ijtag_tck      : scan clock (shift on posedge, update/enable on negedge)
//   ijtag_reset    : asynchronous active-low reset
//   ijtag_sel      : segment select
//   ijtag_ce       : capture enable
//   ijtag_se       : shift enable
//   ijtag_ue       : update enable
//   ijtag_si       : scan-in
//   ijtag_so       : scan-out
//   ijtag_from_so  : scan-out of child i on bit i
//   ijtag_to_si    : scan-in for child i
//   ijtag_to_sel   : select for child i
//   ijtag_open     : update-latch value (which children are open)
// ----------------------------------------------------------------------------
module ijtag_multi_sib #(
    parameter int unsigned NUM_CH         = 4,
    parameter bit          RETIME_SO      = 1'b1,
    parameter bit          CAPTURE_STATUS = 1'b0
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    input  logic              ijtag_si,
    output logic              ijtag_so,
    input  logic [NUM_CH-1:0] ijtag_from_so,
    output logic [NUM_CH-1:0] ijtag_to_si,
    output logic [NUM_CH-1:0] ijtag_to_sel,
    output logic [NUM_CH-1:0] ijtag_open
);

    logic [NUM_CH-1:0] sib;
    logic [NUM_CH-1:0] sib_latch;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] shift_next;

    // Previous stage of each bit: scan-in for bit 0, the lower SIB bit otherwise.
    always_comb begin
        prev    = '0;
        prev[0] = ijtag_si;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            prev[i] = sib[i-1];
        end
    end

    // An open bit takes its child's scan-out; a closed bit bypasses the child.
    always_comb begin
        shift_next = (sib_latch & ijtag_from_so) | (~sib_latch & prev);
    end

    // Shift register: capture has priority over shift; holds when deselected.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sib <= '0;
        end else if (ijtag_sel && ijtag_ce) begin
            sib <= CAPTURE_STATUS ? sib_latch : '0;
        end else if (ijtag_sel && ijtag_se) begin
            sib <= shift_next;
        end
    end

    // Update latch and enable register. en trails sib_latch by one negedge so
    // a child opens or closes one tck cycle after its update; en is loaded
    // regardless of sel.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sib_latch <= '0;
            en        <= '0;
        end else begin
            if (ijtag_sel && ijtag_ue) begin
                sib_latch <= sib;
            end
            en <= sib_latch;
        end
    end

    assign ijtag_to_si  = prev;
    assign ijtag_to_sel = en & {NUM_CH{ijtag_sel}};
    assign ijtag_open   = sib_latch;

    generate
        if (RETIME_SO) begin : g_retime
            logic so_q;
            // Transparent while tck is low, so scan-out moves half a cycle
            // after the shifting posedge and is stable across the next one.
            always_latch begin
                if (!ijtag_reset) begin
                    so_q <= 1'b0;
                end else if (!ijtag_tck) begin
                    so_q <= sib[NUM_CH-1];
                end
            end
            assign ijtag_so = so_q;
        end else begin : g_direct
            assign ijtag_so = sib[NUM_CH-1];
        end
    endgenerate

endmodule
